// File: rtl/bus_pkg.sv
// Shared types and constants for the serial bus master ports.
package bus_pkg;

  localparam int unsigned ADDR_W        = 14;
  localparam int unsigned DATA_W        = 8;
  localparam int unsigned SLAVE_SEL_MSB = 13;
  localparam int unsigned SLAVE_SEL_LSB = 12;
  localparam int unsigned SEL_W         = SLAVE_SEL_MSB - SLAVE_SEL_LSB + 1;

  localparam logic [ADDR_W-1:0] SLAVE0_BASE = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] SLAVE1_BASE = ADDR_W'(4096);
  localparam logic [ADDR_W-1:0] SLAVE2_BASE = ADDR_W'(8192);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    WDATA,
    WAIT_ACK,
    RDATA,
    DONE
  } state_t;

  // Transaction captured from the controller when a request is accepted.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } bus_req_t;

  function automatic logic [SEL_W-1:0] slave_sel(input logic [ADDR_W-1:0] addr);
    return addr[SLAVE_SEL_MSB:SLAVE_SEL_LSB];
  endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// MSB-first shift register with parallel load, serial in/out and a bit down-counter.
module bus_shift_reg
  import bus_pkg::*;
#(
  parameter int unsigned W     = ADDR_W,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [W-1:0]     load_val,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             shift,
  input  logic             sin,
  output logic [W-1:0]     q,
  output logic             sout,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      q   <= load_val;
      cnt <= load_cnt;
    end else if (shift) begin
      q   <= {q[W-2:0], sin};
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign sout = q[W-1];
  assign last = (cnt == '0);

endmodule

// File: rtl/bus_master_port.sv
// Master-side serial bus port: arbitrates, shifts out address/write data, collects read data.
// Optional ack/read-data timeout enabled with `define BUS_MASTER_TIMEOUT_EN.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              read_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              m_grant,
  input  logic              s_ack,
  input  logic              s_valid,
  input  logic              s_din,
  output logic              m_request,
  output logic              m_valid,
  output logic              m_dout,
  output logic              m_rw,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              busy,
  output logic              error
);

  localparam int unsigned CNT_W = $clog2(ADDR_W);
  localparam int unsigned PAD_W = ADDR_W - DATA_W;

  state_t   state, next_state;
  bus_req_t req_q;

  logic              sr_load, sr_shift, sr_sin, sr_sout, sr_last;
  logic [ADDR_W-1:0] sr_load_val, sr_q;
  logic [CNT_W-1:0]  sr_load_cnt;
  logic              accept, rd_load, rw_next;
  logic              m_request_d, m_valid_d, m_rw_d, done_d, busy_d;
  logic              sr_unused;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
  logic [TCNT_W-1:0] tcnt;
  logic              to_expired, to_hit;
  assign to_expired = (tcnt == TCNT_W'(TIMEOUT - 1));
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT != 0);
  assign error          = 1'b0;
`endif

  bus_shift_reg #(.W(ADDR_W), .CNT_W(CNT_W)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (sr_load),
    .load_val (sr_load_val),
    .load_cnt (sr_load_cnt),
    .shift    (sr_shift),
    .sin      (sr_sin),
    .q        (sr_q),
    .sout     (sr_sout),
    .last     (sr_last)
  );

  // The shifter MSB is a flop and is cleared whenever no address/data bit is on the wire.
  assign m_dout    = sr_sout;
  assign sr_unused = ^sr_q[ADDR_W-1:DATA_W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_q     <= '0;
      m_request <= 1'b0;
      m_valid   <= 1'b0;
      m_rw      <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      m_request <= m_request_d;
      m_valid   <= m_valid_d;
      m_rw      <= m_rw_d;
      rd_valid  <= rd_load;
      done      <= done_d;
      busy      <= busy_d;
      if (accept) req_q <= '{rw: read_en, addr: addr_in, data: data_in};
      if (rd_load) rd_data <= {sr_q[DATA_W-2:0], s_din};
    end
  end

  // Next state, shifter control and next values of the registered outputs.
  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    rd_load     = 1'b0;
    sr_load     = 1'b0;
    sr_load_val = '0;
    sr_load_cnt = '0;
    sr_shift    = 1'b0;
    sr_sin      = 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
    to_hit      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (enable) begin
          accept     = 1'b1;
          next_state = REQ;
          sr_load    = 1'b1;
        end
      end
      REQ: begin
        if (m_grant) begin
          next_state  = ADDR;
          sr_load     = 1'b1;
          sr_load_val = req_q.addr;
          sr_load_cnt = CNT_W'(ADDR_W - 1);
        end
      end
      ADDR: begin
        if (!m_grant) begin
          next_state = REQ;
          sr_load    = 1'b1;
        end else if (sr_last) begin
          sr_load     = 1'b1;
          sr_load_cnt = CNT_W'(DATA_W - 1);
          if (req_q.rw) begin
            next_state = RDATA;
          end else begin
            next_state  = WDATA;
            sr_load_val = {req_q.data, PAD_W'(0)};
          end
        end else begin
          sr_shift = 1'b1;
        end
      end
      WDATA: begin
        if (!m_grant) begin
          next_state = REQ;
          sr_load    = 1'b1;
        end else if (sr_last) begin
          next_state = WAIT_ACK;
          sr_load    = 1'b1;
        end else begin
          sr_shift = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (s_ack) begin
          next_state = DONE;
        end
`ifdef BUS_MASTER_TIMEOUT_EN
        else if (to_expired) begin
          next_state = DONE;
          to_hit     = 1'b1;
        end
`endif
      end
      RDATA: begin
        if (s_valid && sr_last) begin
          next_state = DONE;
          rd_load    = 1'b1;
          sr_load    = 1'b1;
        end else begin
          if (s_valid) begin
            sr_shift = 1'b1;
            sr_sin   = s_din;
          end
`ifdef BUS_MASTER_TIMEOUT_EN
          if (to_expired) begin
            next_state = DONE;
            to_hit     = 1'b1;
            sr_load    = 1'b1;
            sr_shift   = 1'b0;
          end
`endif
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase

    m_request_d = next_state inside {REQ, ADDR, WDATA, WAIT_ACK, RDATA};
    m_valid_d   = next_state inside {ADDR, WDATA};
    busy_d      = (next_state != IDLE);
    done_d      = (next_state == DONE);
    rw_next     = accept ? read_en : req_q.rw;
    m_rw_d      = m_request_d & rw_next;
  end

`ifdef BUS_MASTER_TIMEOUT_EN
  // Wait-cycle counter restarts on every entry to WAIT_ACK or RDATA; error is sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt  <= '0;
      error <= 1'b0;
    end else begin
      if (state inside {WAIT_ACK, RDATA}) tcnt <= tcnt + TCNT_W'(1);
      else                                tcnt <= '0;
      if (accept)      error <= 1'b0;
      else if (to_hit) error <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: transaction table plus hand-written grant-loss, busy-enable and reset sequences.
module tb_bus_master_port;
  import bus_pkg::*;

  logic              clk = 1'b0;
  logic              reset, enable, read_en, m_grant, s_ack, s_valid, s_din;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] addr_in;
  logic              m_request, m_valid, m_dout, m_rw, rd_valid, done, busy, error;
  logic [DATA_W-1:0] rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic              exp_bits[$];
  logic [DATA_W-1:0] exp_rd[$];

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                gdly;
    int                gap;
    int                ack_dly;
    int                exp_lat;
  } txn_t;

  txn_t tbl[6];

  always #5 clk = ~clk;

  bus_master_port #(.TIMEOUT(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .read_en   (read_en),
    .data_in   (data_in),
    .addr_in   (addr_in),
    .m_grant   (m_grant),
    .s_ack     (s_ack),
    .s_valid   (s_valid),
    .s_din     (s_din),
    .m_request (m_request),
    .m_valid   (m_valid),
    .m_dout    (m_dout),
    .m_rw      (m_rw),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .done      (done),
    .busy      (busy),
    .error     (error)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every valid serial bit and every read completion is popped and compared.
  always @(posedge clk) begin
    logic b;
    logic [DATA_W-1:0] d;
    #1;
    if (!reset) begin
      if (m_valid) begin
        if (exp_bits.size() == 0) check("serial_extra", 32'(m_valid), 0);
        else begin
          b = exp_bits.pop_front();
          check("serial_bit", 32'(m_dout), 32'(b));
        end
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) check("rd_extra", 32'(rd_valid), 0);
        else begin
          d = exp_rd.pop_front();
          check("rd_word", 32'(rd_data), 32'(d));
        end
      end
    end
  end

  task automatic push_stream(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    for (int i = ADDR_W - 1; i >= 0; i--) exp_bits.push_back(a[i]);
    if (!rw) for (int i = DATA_W - 1; i >= 0; i--) exp_bits.push_back(d[i]);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req"},    32'(m_request), 0);
    check({tag, "_valid"},  32'(m_valid), 0);
    check({tag, "_dout"},   32'(m_dout), 0);
    check({tag, "_rw"},     32'(m_rw), 0);
    check({tag, "_rddata"}, 32'(rd_data), 0);
    check({tag, "_rdv"},    32'(rd_valid), 0);
    check({tag, "_done"},   32'(done), 0);
    check({tag, "_busy"},   32'(busy), 0);
    check({tag, "_error"},  32'(error), 0);
  endtask

  task automatic start(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    enable  = 1'b1;
    read_en = rw;
    addr_in = a;
    data_in = d;
    cyc();
    enable  = 1'b0;
    read_en = ~rw;
    addr_in = ~a;
    data_in = ~d;
    check("req_rise", 32'(m_request), 1);
    check("busy_rise", 32'(busy), 1);
  endtask

  // Runs REQ + serial phase; n = cycles after accept until the wire goes quiet with the stream drained.
  task automatic phase(input int gdly, input int inj, output int n);
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      if (k - 1 == gdly) m_grant = 1'b1;
      if (k == inj) begin
        enable  = 1'b1;
        read_en = 1'b1;
        addr_in = 14'd5098;
        data_in = 8'h00;
      end
      if (k == inj + 1) enable = 1'b0;
      cyc();
      n = k;
      if (!m_valid && m_request && exp_bits.size() == 0) break;
    end
  endtask

  task automatic finish_write(input int ack_dly);
    repeat (ack_dly) cyc();
    check("ack_wait_done", 32'(done), 0);
    check("ack_wait_req", 32'(m_request), 1);
    s_ack   = 1'b1;
    m_grant = 1'b0;
    cyc();
    s_ack = 1'b0;
    check("wr_done", 32'(done), 1);
    check("wr_req_fall", 32'(m_request), 0);
    check("wr_no_rdv", 32'(rd_valid), 0);
    cyc();
    check("wr_done_pulse", 32'(done), 0);
    check("wr_idle_busy", 32'(busy), 0);
  endtask

  task automatic finish_read(input logic [DATA_W-1:0] d, input int gap);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (i == gap) begin
        s_valid = 1'b0;
        cyc();
        check("rd_stall_done", 32'(done), 0);
      end
      s_valid = 1'b1;
      s_din   = d[i];
      cyc();
    end
    s_valid = 1'b0;
    s_din   = 1'b0;
    check("rd_done", 32'(done), 1);
    check("rd_valid", 32'(rd_valid), 1);
    check("rd_data", 32'(rd_data), 32'(d));
    check("rd_req_fall", 32'(m_request), 0);
    cyc();
    check("rd_valid_pulse", 32'(rd_valid), 0);
    check("rd_done_pulse", 32'(done), 0);
    check("rd_data_hold", 32'(rd_data), 32'(d));
    check("rd_idle_busy", 32'(busy), 0);
  endtask

  task automatic do_txn(input txn_t t);
    int n;
    push_stream(t.rw, t.addr, t.data);
    if (t.rw) exp_rd.push_back(t.data);
    m_grant = 1'b0;
    start(t.rw, t.addr, t.data);
    phase(t.gdly, -1, n);
    check("latency", n, t.exp_lat);
    check("m_rw", 32'(m_rw), 32'(t.rw));
    check("req_held", 32'(m_request), 1);
    m_grant = 1'b0;
    if (t.rw) finish_read(t.data, t.gap);
    else      finish_write(t.ack_dly);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   n;
    txn_t t;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;

    reset = 1'b1; enable = 1'b0; read_en = 1'b0; data_in = '0; addr_in = '0;
    m_grant = 1'b0; s_ack = 1'b0; s_valid = 1'b0; s_din = 1'b0;

    tbl[0] = '{rw: 1'b0, addr: 14'd1001,  data: 8'd101,  gdly: 0, gap: -1, ack_dly: 1, exp_lat: 23};
    tbl[1] = '{rw: 1'b1, addr: 14'd9193,  data: 8'hA5,   gdly: 0, gap: 4,  ack_dly: 0, exp_lat: 15};
    tbl[2] = '{rw: 1'b0, addr: 14'd4096,  data: 8'hFF,   gdly: 5, gap: -1, ack_dly: 3, exp_lat: 28};
    tbl[3] = '{rw: 1'b1, addr: 14'd16383, data: 8'h00,   gdly: 2, gap: -1, ack_dly: 0, exp_lat: 17};
    tbl[4] = '{rw: 1'b0, addr: 14'd0,     data: 8'h80,   gdly: 0, gap: -1, ack_dly: 0, exp_lat: 23};
    tbl[5] = '{rw: 1'b1, addr: 14'd8192,  data: 8'h5A,   gdly: 1, gap: 0,  ack_dly: 0, exp_lat: 16};

    repeat (3) cyc();
    check_idle("reset");
    reset = 1'b0;
    cyc();
    check_idle("post_reset");

    for (int i = 0; i < 6; i++) do_txn(tbl[i]);

    // Grant arrives late, then drops after eight address bits; the address restarts from bit 13.
    a = 14'd1001;
    d = 8'd101;
    for (int i = ADDR_W - 1; i >= 6; i--) exp_bits.push_back(a[i]);
    push_stream(1'b0, a, d);
    m_grant = 1'b0;
    start(1'b0, a, d);
    repeat (5) cyc();
    check("gl_wait_valid", 32'(m_valid), 0);
    m_grant = 1'b1;
    repeat (8) cyc();
    check("gl_valid_before", 32'(m_valid), 1);
    m_grant = 1'b0;
    cyc();
    check("gl_valid_drop", 32'(m_valid), 0);
    check("gl_req_held", 32'(m_request), 1);
    cyc();
    check("gl_req_held2", 32'(m_request), 1);
    phase(0, -1, n);
    check("gl_latency", n, 23);
    check("gl_drained", exp_bits.size(), 0);
    finish_write(0);

    // A second enable during WDATA must be ignored.
    push_stream(1'b0, a, d);
    m_grant = 1'b0;
    start(1'b0, a, d);
    phase(0, 18, n);
    check("busy_en_latency", n, 23);
    check("busy_en_rw", 32'(m_rw), 0);
    finish_write(1);
    repeat (2) begin
      cyc();
      check("busy_en_no_req", 32'(m_request), 0);
    end

    // Reset in the middle of RDATA aborts without a done pulse.
    a = 14'd9193;
    push_stream(1'b1, a, 8'h00);
    m_grant = 1'b0;
    start(1'b1, a, 8'h00);
    phase(0, -1, n);
    check("rst_rd_latency", n, 15);
    m_grant = 1'b0;
    s_valid = 1'b1;
    s_din   = 1'b1;
    repeat (3) cyc();
    reset   = 1'b1;
    s_valid = 1'b0;
    cyc();
    check_idle("rst_mid");
    reset = 1'b0;
    exp_bits.delete();
    exp_rd.delete();
    cyc();
    check("rst_no_done", 32'(done), 0);
    check("rst_no_req", 32'(m_request), 0);
    t = '{rw: 1'b0, addr: 14'd5097, data: 8'h3C, gdly: 0, gap: -1, ack_dly: 2, exp_lat: 23};
    do_txn(t);

`ifdef BUS_MASTER_TIMEOUT_EN
    // No ack: abort with error after exactly TIMEOUT cycles in WAIT_ACK.
    a = 14'd1001;
    push_stream(1'b0, a, 8'd101);
    m_grant = 1'b0;
    start(1'b0, a, 8'd101);
    phase(0, -1, n);
    check("to_latency", n, 23);
    m_grant = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      cyc();
      n++;
    end
    check("to_cycles", n, 64);
    check("to_error", 32'(error), 1);
    check("to_no_rdv", 32'(rd_valid), 0);
    check("to_req_fall", 32'(m_request), 0);
    cyc();
    check("to_error_sticky", 32'(error), 1);
    push_stream(1'b0, 14'd2, 8'h11);
    start(1'b0, 14'd2, 8'h11);
    check("to_error_clr", 32'(error), 0);
    phase(0, -1, n);
    check("to_next_latency", n, 23);
    finish_write(0);
`endif

    check("sb_bits_empty", exp_bits.size(), 0);
    check("sb_rd_empty", exp_rd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Master-side bus interface, one instance per master (M1, M2).
- Downstream of the test controller: consumes its per-master enable, read_en, data_in and addr_in.
- Requests the arbiter, serialises a 14-bit address and optional 8-bit write data onto the serial bus, and collects 8-bit read data.
- Holds m_request high for the whole transaction; the controller watches this line to return to idle.

Parameters:
- ADDR_W, 14, address width; bits [13:12] select the slave, bits [11:0] are the in-slave address.
- DATA_W, 8, data width.
- TIMEOUT, 64, cycles allowed in ACK/RDATA wait before abort (used only with the macro).

Ports:
- clk  in  1  system clock, posedge.
- reset  in  1  synchronous, active-high.
- enable  in  1  start transaction; sampled in IDLE only.
- read_en  in  1  1=read, 0=write; latched with enable.
- data_in  in  DATA_W  write data; latched with enable.
- addr_in  in  ADDR_W  target address; latched with enable.
- m_grant  in  1  arbiter grant.
- s_ack  in  1  slave write-complete pulse.
- s_valid  in  1  slave read-data bit valid.
- s_din  in  1  slave read-data bit.
- m_request  out  1  bus request to arbiter and controller.
- m_valid  out  1  m_dout carries a valid bit.
- m_dout  out  1  serial address/data bit, MSB first.
- m_rw  out  1  latched read_en, driven while m_request=1.
- rd_data  out  DATA_W  last read word.
- rd_valid  out  1  one-cycle pulse, read complete.
- done  out  1  one-cycle pulse, transaction complete.
- busy  out  1  high in every state except IDLE.
- error  out  1  sticky timeout flag; cleared on next accepted enable.

Behaviour:
- Reset: state=IDLE, all outputs 0, rd_data=0, bit counter=0, latched registers=0. Reset mid-transaction aborts immediately with no done pulse.
- IDLE: on enable=1, latch addr_in, data_in and read_en, then go to REQ. Enable in any other state is ignored.
- REQ: m_request=1. Wait for m_grant=1, then go to ADDR with bit counter=ADDR_W-1.
- ADDR: m_valid=1, m_dout=addr[cnt], counter decrements each cycle, 14 cycles total.
  - At cnt=0: write goes to WDATA (cnt=DATA_W-1); read goes to RDATA (cnt=DATA_W-1).
- WDATA: m_valid=1, m_dout=data[cnt], 8 cycles, then WAIT_ACK.
- Grant loss: if m_grant drops during ADDR or WDATA, set m_valid=0, go to REQ and restart from address MSB. m_request stays 1.
- WAIT_ACK: m_valid=0. On s_ack=1, go to DONE.
- RDATA: each cycle with s_valid=1, shift s_din into a shift register MSB-first and decrement cnt. Cycles with s_valid=0 stall. After the 8th bit, load rd_data and go to DONE.
- DONE (1 cycle): m_request=0, done=1; rd_valid=1 if read. Next state IDLE.
- Minimum latency, grant present at REQ, first edge counted from enable accepted in IDLE:
  - write: 1 (IDLE→REQ) + 1 (REQ→ADDR) + 14 + 8 + ack wait + 1 (DONE).
  - read: 1 + 1 + 14 + 8 s_valid cycles + 1 (DONE).
- If s_ack and m_grant drop occur in the same cycle during WAIT_ACK, s_ack wins (grant is ignored after the data phase).

Optional Feature:
- Macro: BUS_MASTER_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_ACK and RDATA and is cleared on entry to each.
  - Reaching TIMEOUT: error=1, go to DONE with done=1 and rd_valid=0. rd_data is unchanged.
- Undefined: no counter, error tied to 0, WAIT_ACK and RDATA wait indefinitely.

Decomposition:
- Shared package bus_pkg holds:
  - state enum (IDLE, REQ, ADDR, WDATA, WAIT_ACK, RDATA, DONE);
  - ADDR_W, DATA_W, SLAVE_SEL_MSB=13, SLAVE_SEL_LSB=12;
  - slave base constants 0, 4096, 8192.
- One sub-module, bus_shift_reg: parallel-load / serial-out plus serial-in / parallel-out, with a down-counter and last-bit flag. Reused for both the address and data phases.

Test Plan:
- Write: enable, read_en=0, addr=1001, data=101, grant held high → m_dout carries 1001 MSB-first over 14 cycles, then 101 (0x65) over 8 cycles; s_ack at cycle 25 → done pulse, m_request falls in the DONE cycle.
- Read: addr=9193, read_en=1, slave returns 0xA5 with s_valid gapped (one idle cycle mid-word) → rd_data=0xA5, rd_valid=1 for exactly one cycle.
- Grant delay and loss: grant arrives 5 cycles after REQ and drops after address bit 6 → m_valid=0, request held; after regrant, all 14 address bits are resent from bit 13.
- Enable while busy: second enable with addr=5098 mid-WDATA → ignored; the first transaction completes with addr 1001.
- Reset: reset during RDATA → next cycle all outputs 0, state IDLE, no done pulse; a fresh write to 5097 afterwards completes normally.
- Timeout (macro on, TIMEOUT=64): write with no s_ack → error=1 and done=1 exactly 64 cycles after WAIT_ACK entry; next enable clears error.
